led_pwm_fader: RTL and testbench
================================

# led_pwm_fader

Per-LED PWM brightness fader placed between the free-running binary LED counter and the board LED pins. It takes the counter's on/off bit per LED as a target and, instead of switching LEDs abruptly, ramps each channel's brightness linearly up or down. Output is a glitch-free PWM waveform per LED. All logic runs in the single board clock domain.

## Interface

Parameters:
- CHANNELS, 4: number of LED channels.
- PWM_BITS, 8: brightness resolution. MAX = 2^PWM_BITS - 1.
- STEP_DIV, 1024: clock cycles per brightness step. Must be ≥ 1.

Ports:
- clk  input  1  board clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- target  input  CHANNELS  per-channel goal: 1 ramps toward MAX, 0 ramps toward 0. Synchronous to clk.
- led  output  CHANNELS  registered PWM output per channel.
- busy  output  1  registered; 1 while any channel level differs from its goal.
- frame_strobe  output  1  registered one-cycle pulse at the start of each PWM frame.

## Operation

- pwm_cnt (PWM_BITS wide) counts 0..MAX-1, then wraps to 0.
  - PWM frame = MAX cycles.
  - Count MAX is never reached.
- div_cnt counts 0..STEP_DIV-1, then wraps.
  - step is true in the cycle where div_cnt == STEP_DIV-1.
  - With STEP_DIV = 1, step is true every cycle.
- Per channel i, working register level[i] (PWM_BITS wide). On step:
  - target[i]=1 and level[i]<MAX: level[i] += 1.
  - target[i]=0 and level[i]>0: level[i] -= 1.
  - Otherwise: hold. Saturating; never wraps.
- A target change mid-ramp reverses direction from the current level. No jump, no restart.
- Shadow register level_sh[i] loads level[i] only in cycles where pwm_cnt == MAX-1, i.e. the last cycle of a frame. The new value applies from the next frame.
- led[i] <= (pwm_cnt < level_sh[i]). Unsigned compare at PWM_BITS width.
  - level_sh = 0: constantly low.
  - level_sh = MAX: constantly high.
  - level_sh = k: high for the first k cycles of each frame.
- frame_strobe <= (pwm_cnt == MAX-1).
- busy <= OR over i of (level[i] != (target[i] ? MAX : 0)).
- Reset (async, rst=1): pwm_cnt, div_cnt, level, level_sh, led, busy and frame_strobe all clear to 0 immediately. Counting resumes on the first clk edge after rst deasserts.

## Timing

- Output latency: led and frame_strobe reflect the pwm_cnt value of the previous cycle (1 clk).
- First rising edge after reset release: pwm_cnt 0→1; led[i]=0 because level_sh=0.
- frame_strobe is high in the cycle where pwm_cnt == 0.
- Step cadence: first step occurs at the STEP_DIV-th edge after reset release.
- Full ramp 0→MAX takes MAX·STEP_DIV cycles. The visible effect is delayed by up to one additional frame because of the shadow register.
- busy lags its combinational condition by 1 cycle. busy falls the cycle after the final step.
- Simultaneous step and shadow load in the same cycle: the shadow loads the pre-step level. The post-step value appears one frame later.
- target toggling every cycle has no effect between steps; only the value at a step edge matters.
- rst asserted mid-ramp or mid-frame: led drops to 0 asynchronously, without waiting for clk.

## Test plan

All scenarios use PWM_BITS=4 (MAX=15, frame 15 cycles), STEP_DIV=4, CHANNELS=4.

- Reset idle: rst=1 for 3 cycles, then target=0000 for 200 cycles → led=0000, busy=0 throughout; frame_strobe pulses every 15 cycles, first pulse 15 cycles after release.
- Ramp up: target=0001 from reset release → level[0] reaches 15 at cycle 60; busy=1 from cycle 1 until cycle 61; after the next frame_strobe, led[0]=1 constantly; led[3:1]=0.
- Duty: sample the frame in which level_sh[0]=5 → led[0] high for exactly 5 consecutive cycles starting 1 cycle after frame_strobe, then low for 10.
- Reversal: target=0001 for 22 cycles (level[0]=5), then target=0000 → level[0] steps 5,4,3,2,1,0 at 4-cycle spacing with no jump to 15 or 0; busy falls 1 cycle after level[0] reaches 0.
- Shadow isolation: a level change in mid-frame → led duty for the current frame is unchanged; the new duty appears in the frame after the next frame_strobe.
- Async reset mid-ramp: target=1111, assert rst between clk edges at level=9 → led=0000 before the next edge; after release, all levels restart from 0.

Source files
------------

// File: rtl/led_pwm_fader.sv
// Per-LED PWM brightness fader: ramps each channel linearly toward its on/off
// target and drives a frame-synchronous, glitch-free PWM output per LED.
module led_pwm_fader #(
    parameter int CHANNELS = 4,
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] target,
    output logic [CHANNELS-1:0] led,
    output logic                busy,
    output logic                frame_strobe
);

    localparam logic [PWM_BITS-1:0] MAX_LVL  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] ZERO_LVL = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] ONE_LVL  = PWM_BITS'(1);
    // The frame is MAX cycles long, so the counter wraps after MAX-1.
    localparam logic [PWM_BITS-1:0] LAST_CNT = MAX_LVL - ONE_LVL;
    localparam int                  DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0]    DIV_ZERO = {DIV_W{1'b0}};

    logic [PWM_BITS-1:0]               r_pwm_cnt;
    logic [DIV_W-1:0]                  r_div_cnt;
    logic [CHANNELS-1:0][PWM_BITS-1:0] r_level;
    logic [CHANNELS-1:0][PWM_BITS-1:0] r_level_sh;
    logic [CHANNELS-1:0][PWM_BITS-1:0] w_level_nxt;
    logic [CHANNELS-1:0]               w_led_nxt;
    logic                              w_step;
    logic                              w_frame_end;
    logic                              w_busy_nxt;

    // Step and end-of-frame decode.
    always_comb begin
        w_step      = (r_div_cnt == DIV_LAST);
        w_frame_end = (r_pwm_cnt == LAST_CNT);
    end

    // Saturating level update, PWM compare and busy condition per channel.
    always_comb begin
        w_level_nxt = r_level;
        w_led_nxt   = {CHANNELS{1'b0}};
        w_busy_nxt  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_step && target[i] && (r_level[i] != MAX_LVL)) begin
                w_level_nxt[i] = r_level[i] + ONE_LVL;
            end else if (w_step && !target[i] && (r_level[i] != ZERO_LVL)) begin
                w_level_nxt[i] = r_level[i] - ONE_LVL;
            end else begin
                w_level_nxt[i] = r_level[i];
            end
            w_led_nxt[i] = (r_pwm_cnt < r_level_sh[i]);
            w_busy_nxt   = w_busy_nxt | (r_level[i] != (target[i] ? MAX_LVL : ZERO_LVL));
        end
    end

    // Free-running PWM frame counter and step divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= ZERO_LVL;
            r_div_cnt <= DIV_ZERO;
        end else begin
            r_pwm_cnt <= w_frame_end ? ZERO_LVL : (r_pwm_cnt + ONE_LVL);
            r_div_cnt <= w_step ? DIV_ZERO : (r_div_cnt + DIV_ONE);
        end
    end

    // Working levels; the shadow copy only changes at a frame boundary so a
    // frame never sees two different duty values (it takes the pre-step level).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level    <= {CHANNELS{ZERO_LVL}};
            r_level_sh <= {CHANNELS{ZERO_LVL}};
        end else begin
            r_level <= w_level_nxt;
            if (w_frame_end) begin
                r_level_sh <= r_level;
            end else begin
                r_level_sh <= r_level_sh;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led          <= {CHANNELS{1'b0}};
            busy         <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            led          <= w_led_nxt;
            busy         <= w_busy_nxt;
            frame_strobe <= w_frame_end;
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader with MAX=15, STEP_DIV=4, four channels.
module tb_led_pwm_fader;

    logic       clk;
    logic       rst;
    logic [3:0] target;
    logic [3:0] led;
    logic       busy;
    logic       frame_strobe;

    int n_cmp;
    int n_bad;

    led_pwm_fader #(
        .CHANNELS(4),
        .PWM_BITS(4),
        .STEP_DIV(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .target      (target),
        .led         (led),
        .busy        (busy),
        .frame_strobe(frame_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release happens on a falling edge, so the next rising edge is edge 1.
    task automatic do_reset(input logic [3:0] tgt);
        @(negedge clk);
        rst    = 1'b1;
        target = tgt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic exp_fs;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({led, busy, frame_strobe} !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_hold got %b exp %b", {led, busy, frame_strobe}, 6'b0);
            end
        end
        rst = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            exp_fs = ((n % 15) == 0);
            n_cmp++;
            if ({led, busy, frame_strobe} !== {4'b0000, 1'b0, exp_fs}) begin
                n_bad++;
                $display("FAIL idle n=%0d got %b exp %b", n, {led, busy, frame_strobe},
                         {4'b0000, 1'b0, exp_fs});
            end
        end
    endtask

    task automatic test_ramp_up();
        logic exp_busy;
        logic exp_led0;
        do_reset(4'b0001);
        for (int n = 1; n <= 105; n++) begin
            tick();
            exp_busy = (n <= 60);
            n_cmp++;
            if (busy !== exp_busy) begin
                n_bad++;
                $display("FAIL ramp_busy n=%0d got %b exp %b", n, busy, exp_busy);
            end
            n_cmp++;
            if (led[3:1] !== 3'b000) begin
                n_bad++;
                $display("FAIL ramp_idle_ch n=%0d got %b exp 000", n, led[3:1]);
            end
            if (n >= 61) begin
                exp_led0 = (n != 75);
                n_cmp++;
                if (led[0] !== exp_led0) begin
                    n_bad++;
                    $display("FAIL ramp_led0 n=%0d got %b exp %b", n, led[0], exp_led0);
                end
            end
            if (n == 74 || n == 75) begin
                n_cmp++;
                if (frame_strobe !== (n == 75)) begin
                    n_bad++;
                    $display("FAIL ramp_strobe n=%0d got %b exp %b", n, frame_strobe, (n == 75));
                end
            end
        end
    endtask

    // Levels: 5 at edge 20, 4 at 24 (target low), 5 at 28, then up to 15 at 68.
    // Shadow duties per frame: 0, 3, 5, 9, 12 (pre-step value at edge 60), 15.
    task automatic test_duty_shadow();
        logic exp_led0;
        do_reset(4'b0001);
        for (int n = 1; n <= 90; n++) begin
            target = (n >= 21 && n <= 24) ? 4'b0000 : 4'b0001;
            tick();
            exp_led0 = (n >= 16 && n <= 18) || (n >= 31 && n <= 35) ||
                       (n >= 46 && n <= 54) || (n >= 61 && n <= 72) || (n >= 76);
            n_cmp++;
            if (led !== {3'b000, exp_led0}) begin
                n_bad++;
                $display("FAIL duty n=%0d got %b exp %b", n, led, {3'b000, exp_led0});
            end
            n_cmp++;
            if (busy !== (n <= 68)) begin
                n_bad++;
                $display("FAIL duty_busy n=%0d got %b exp %b", n, busy, (n <= 68));
            end
            if (n == 30) begin
                n_cmp++;
                if (frame_strobe !== 1'b1) begin
                    n_bad++;
                    $display("FAIL duty_strobe n=%0d got %b exp 1", n, frame_strobe);
                end
            end
        end
    endtask

    task automatic test_reversal();
        logic [3:0] exp_lvl;
        do_reset(4'b0001);
        for (int n = 1; n <= 45; n++) begin
            target = (n <= 22) ? 4'b0001 : 4'b0000;
            tick();
            if (n <= 23)      exp_lvl = 4'(n / 4);
            else if (n <= 39) exp_lvl = 4'(5 - ((n - 20) / 4));
            else              exp_lvl = 4'd0;
            n_cmp++;
            if (dut.r_level[0] !== exp_lvl) begin
                n_bad++;
                $display("FAIL rev_level n=%0d got %0d exp %0d", n, dut.r_level[0], exp_lvl);
            end
            n_cmp++;
            if (busy !== (n <= 40)) begin
                n_bad++;
                $display("FAIL rev_busy n=%0d got %b exp %b", n, busy, (n <= 40));
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] exp_led;
        do_reset(4'b1111);
        repeat (37) tick();
        n_cmp++;
        if ({dut.r_level[0], led} !== {4'd9, 4'b1111}) begin
            n_bad++;
            $display("FAIL pre_rst got lvl=%0d led=%b exp lvl=9 led=1111", dut.r_level[0], led);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({led, busy, frame_strobe} !== 6'b0) begin
            n_bad++;
            $display("FAIL async_rst got %b exp %b", {led, busy, frame_strobe}, 6'b0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            exp_led = (n >= 16 && n <= 18) ? 4'b1111 : 4'b0000;
            n_cmp++;
            if ({led, busy} !== {exp_led, 1'b1}) begin
                n_bad++;
                $display("FAIL restart n=%0d got %b exp %b", n, {led, busy}, {exp_led, 1'b1});
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        target = 4'b0000;
        test_reset();
        test_ramp_up();
        test_duty_shadow();
        test_reversal();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
